// File: rtl/mn_matrix_pkg.sv
// Shared definitions for the matrix stream reader: FSM encoding, default widths, FIFO entry tags.
package mn_matrix_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_DIM_W      = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Per-element tags carried alongside the data through the output buffer.
    typedef struct packed {
        logic row_end;
        logic last;
    } tag_t;

endpackage

// File: rtl/mn_stream_fifo.sv
// Fall-through output buffer: an element pushed into an empty buffer is presented the same cycle.
module mn_stream_fifo
    import mn_matrix_pkg::*;
#(
    parameter int unsigned W     = DEF_DATA_W,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         push_row_end,
    input  logic                         push_last,
    input  logic                         ready,
    output logic                         valid,
    output logic [W-1:0]                 data,
    output logic                         row_end,
    output logic                         last,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = W + $bits(tag_t);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] head;
    tag_t             in_tag;
    tag_t             head_tag;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    assign in_tag.row_end = push_row_end;
    assign in_tag.last    = push_last;
    assign empty    = (level == '0);
    assign head     = empty ? {in_tag, push_data} : mem[rd_ptr];
    assign head_tag = head[ENT_W-1:W];

    // An empty buffer with a push and a taker passes the element straight through without storing it.
    assign valid = !empty || push;
    assign wr_en = push && !(empty && ready);
    assign rd_en = ready && !empty;

    // Outputs are forced to zero whenever nothing is being presented.
    assign data    = valid ? head[W-1:0] : '0;
    assign row_end = valid && head_tag.row_end;
    assign last    = valid && head_tag.last;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_tag, push_data};
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(wr_en) - LVL_W'(rd_en);
        end
    end

endmodule

// File: rtl/mn_matrix_reader.sv
// Streams a matrix out of a 1-cycle-latency element store in row- or column-major order.
module mn_matrix_reader
    import mn_matrix_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned DIM_W      = DEF_DIM_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              transpose,
    input  logic [DIM_W-1:0]  m_dim,
    input  logic [DIM_W-1:0]  n_dim,
    output logic              mat_read,
    output logic              mat_transpose,
    output logic [DIM_W-1:0]  mat_m_dim,
    output logic [DIM_W-1:0]  mat_n_dim,
    output logic [DIM_W-1:0]  mat_m_addr,
    output logic [DIM_W-1:0]  mat_n_addr,
    input  logic [DATA_W-1:0] mat_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_row_end,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = LVL_W + 2;

    state_t           state;
    logic [DIM_W-1:0] outer_lim;
    logic [DIM_W-1:0] inner_lim;
    logic             rd_pend;
    logic             rd_row_end;
    logic             rd_last;
    logic [LVL_W-1:0] level;
    logic             pop;
    logic             inner_wrap;
    logic             final_rd;
    logic [OCC_W-1:0] occ_next;
    logic             credit;

    // The address counters are the registered address outputs themselves (outer on m, inner on n).
    assign pop        = out_valid && out_ready;
    assign inner_wrap = (mat_n_addr == inner_lim - DIM_W'(1));
    assign final_rd   = inner_wrap && (mat_m_addr == outer_lim - DIM_W'(1));

    // mat_read is registered, so credit looks one cycle ahead: next-cycle occupancy plus the
    // read now in flight must leave room for the read about to be issued.
    assign occ_next = OCC_W'(level) + OCC_W'(rd_pend) - OCC_W'(pop);
    assign credit   = (occ_next + OCC_W'(mat_read)) < OCC_W'(FIFO_DEPTH);

    // Control FSM, address counters and read-response tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            outer_lim     <= '0;
            inner_lim     <= '0;
            mat_read      <= 1'b0;
            mat_transpose <= 1'b0;
            mat_m_dim     <= '0;
            mat_n_dim     <= '0;
            mat_m_addr    <= '0;
            mat_n_addr    <= '0;
            rd_pend       <= 1'b0;
            rd_row_end    <= 1'b0;
            rd_last       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done       <= 1'b0;
            rd_pend    <= mat_read;
            rd_row_end <= mat_read && inner_wrap;
            rd_last    <= mat_read && final_rd;
            case (state)
                IDLE: begin
                    if (start) begin
                        mat_m_dim  <= m_dim;
                        mat_n_dim  <= n_dim;
                        outer_lim  <= transpose ? n_dim : m_dim;
                        inner_lim  <= transpose ? m_dim : n_dim;
                        mat_m_addr <= '0;
                        mat_n_addr <= '0;
                        if (m_dim == '0 || n_dim == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            busy          <= 1'b1;
                            mat_transpose <= transpose;
                            mat_read      <= credit;
                        end
                    end
                end
                ISSUE: begin
                    if (mat_read) begin
                        if (inner_wrap) begin
                            mat_n_addr <= '0;
                            mat_m_addr <= mat_m_addr + DIM_W'(1);
                        end else begin
                            mat_n_addr <= mat_n_addr + DIM_W'(1);
                        end
                    end
                    if (mat_read && final_rd) begin
                        state    <= DRAIN;
                        mat_read <= 1'b0;
                    end else begin
                        mat_read <= credit;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state         <= DONE;
                        busy          <= 1'b0;
                        mat_transpose <= 1'b0;
                        done          <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mn_stream_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (rd_pend),
        .push_data    (mat_data),
        .push_row_end (rd_row_end),
        .push_last    (rd_last),
        .ready        (out_ready),
        .valid        (out_valid),
        .data         (out_data),
        .row_end      (out_row_end),
        .last         (out_last),
        .level        (level)
    );

endmodule

// File: tb/tb_mn_matrix_reader.sv
// Bench for mn_matrix_reader: element-store responder, event-level stream model, directed and random runs.
`timescale 1ns/1ps
module tb_mn_matrix_reader;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIM_W  = 32;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              transpose = 1'b0;
    logic [DIM_W-1:0]  m_dim = '0;
    logic [DIM_W-1:0]  n_dim = '0;
    logic              mat_read;
    logic              mat_transpose;
    logic [DIM_W-1:0]  mat_m_dim;
    logic [DIM_W-1:0]  mat_n_dim;
    logic [DIM_W-1:0]  mat_m_addr;
    logic [DIM_W-1:0]  mat_n_addr;
    logic [DATA_W-1:0] mat_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_row_end;
    logic              out_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    mn_matrix_reader #(
        .DATA_W     (DATA_W),
        .DIM_W      (DIM_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .transpose     (transpose),
        .m_dim         (m_dim),
        .n_dim         (n_dim),
        .mat_read      (mat_read),
        .mat_transpose (mat_transpose),
        .mat_m_dim     (mat_m_dim),
        .mat_n_dim     (mat_n_dim),
        .mat_m_addr    (mat_m_addr),
        .mat_n_addr    (mat_n_addr),
        .mat_data      (mat_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row_end   (out_row_end),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              row_end;
        logic              last;
    } elem_t;

    typedef struct {
        int unsigned m_addr;
        int unsigned n_addr;
    } addr_t;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned mat [8][8];
    elem_t       exp_q[$];
    addr_t       addr_q[$];
    elem_t       acc_log[$];

    // Model state: what the stream must look like, tracked as events rather than FSM states.
    bit          active = 0;
    bit          streaming = 0;
    bit          done_due = 0;
    bit          cur_tr = 0;
    bit          prev_stall = 0;
    elem_t       prev_e;
    logic [DIM_W-1:0] lat_m = '0;
    logic [DIM_W-1:0] lat_n = '0;
    int          total = 0;
    int          acc_cnt = 0;
    int          issued = 0;
    int          popped = 0;
    int          valid_cycles = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          first_rd_cyc = -1;
    int          first_val_cyc = -1;
    int          last_acc_cyc = 0;
    int          done_cyc = 0;
    int          rdy_mode = 0;
    int          rdy_ph = 0;
    int unsigned pin_v [6];
    bit          pin_re [6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Element store: returns the addressed element one cycle after each read, garbage otherwise.
    always @(posedge clk) begin
        int unsigned r;
        int unsigned c;
        if (mat_read) begin
            r = mat_transpose ? mat_n_addr : mat_m_addr;
            c = mat_transpose ? mat_m_addr : mat_n_addr;
            if (r < 8 && c < 8) mat_data <= DATA_W'(mat[r][c]);
            else                mat_data <= 32'hDEAD_BEEF;
        end else begin
            mat_data <= DATA_W'($urandom);
        end
    end

    // Downstream readiness patterns.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        rdy_ph++;
    end

    task automatic accept_start();
        int outer;
        int inner;
        int r;
        int c;
        active = 1;
        cur_tr = transpose;
        lat_m = m_dim;
        lat_n = n_dim;
        total = int'(m_dim) * int'(n_dim);
        exp_q.delete();
        addr_q.delete();
        acc_log.delete();
        acc_cnt = 0;
        issued = 0;
        popped = 0;
        valid_cycles = 0;
        start_cyc = cyc;
        first_rd_cyc = -1;
        first_val_cyc = -1;
        outer = transpose ? int'(n_dim) : int'(m_dim);
        inner = transpose ? int'(m_dim) : int'(n_dim);
        for (int o = 0; o < outer; o++) begin
            for (int i = 0; i < inner; i++) begin
                r = transpose ? i : o;
                c = transpose ? o : i;
                exp_q.push_back('{DATA_W'(mat[r][c]), (i == inner - 1), (o == outer - 1) && (i == inner - 1)});
                addr_q.push_back('{o, i});
            end
        end
        if (total == 0) done_due = 1;
        else            streaming = 1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        addr_q.delete();
        active = 0;
        streaming = 0;
        done_due = 0;
        prev_stall = 0;
        valid_cycles = 0;
    endtask

    // Compare process: checks every DUT output against the model once per cycle.
    always @(negedge clk) begin
        elem_t e;
        addr_t a;
        bit    done_now;
        if (!reset) begin
            cyc++;
            chk("done", done, done_due);
            chk("busy", busy, streaming);
            chk("mat_transpose", mat_transpose, streaming && cur_tr);
            if (done) done_cyc = cyc;
            if (out_valid) begin
                valid_cycles++;
                if (first_val_cyc < 0) first_val_cyc = cyc;
                chk("valid_outside_stream", streaming, 1);
            end
            if (streaming) begin
                chk("mat_m_dim", mat_m_dim, lat_m);
                chk("mat_n_dim", mat_n_dim, lat_n);
            end
            if (mat_read) begin
                issued++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                chk("read_outside_stream", streaming, 1);
                chk("read_budget", issued <= total, 1);
                chk("outstanding_le_depth", (issued - popped) <= int'(DEPTH), 1);
                if (addr_q.size() > 0) begin
                    a = addr_q.pop_front();
                    chk("mat_m_addr", mat_m_addr, a.m_addr);
                    chk("mat_n_addr", mat_n_addr, a.n_addr);
                end
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_e.data);
                chk("stall_row_end", out_row_end, prev_e.row_end);
                chk("stall_last", out_last, prev_e.last);
            end
            prev_stall = out_valid && !out_ready;
            prev_e = '{out_data, out_row_end, out_last};
            if (out_valid && out_ready) begin
                chk("accept_budget", acc_cnt < total, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_row_end", out_row_end, e.row_end);
                    chk("out_last", out_last, e.last);
                end
                acc_log.push_back('{out_data, out_row_end, out_last});
                acc_cnt++;
                popped++;
                if (acc_cnt == total) begin
                    last_acc_cyc = cyc;
                    streaming = 0;
                    done_due = 1;
                end
            end
            done_now = done_due && !streaming && (done === 1'b1 || done === 1'b0) ? 1'b0 : 1'b0;
            done_now = (cyc == done_cyc) && done && active && !streaming;
            if (start && !active) accept_start();
            else if (done_now) begin
                active = 0;
                done_due = 0;
            end
            if (!done_now && done_due && cyc != last_acc_cyc && !(start_cyc == cyc && total == 0)) done_due = 0;
        end
    end

    task automatic fill(input int m, input int n, input bit rnd);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mat[r][c] = rnd ? $urandom : int'(r * n + c + 1);
        if (m < 0) mat[0][0] = 0;
    endtask

    task automatic launch(input int m, input int n, input bit tr);
        @(posedge clk); #1;
        start = 1'b1;
        transpose = tr;
        m_dim = DIM_W'(m);
        n_dim = DIM_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        transpose = $urandom_range(0, 1);
        m_dim = DIM_W'($urandom_range(1, 7));
        n_dim = DIM_W'($urandom_range(1, 7));
    endtask

    task automatic wait_done(input bit spurious);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk); #1;
            if (done) seen = 1;
            else begin
                @(posedge clk); #1;
                start = spurious && (i == 2);
                if (start) begin
                    m_dim = 1;
                    n_dim = 1;
                    transpose = ~transpose;
                end
            end
        end
        start = 1'b0;
        chk("done_within_budget", seen, 1);
    endtask

    task automatic pin_seq(input string name);
        chk({name, "_count"}, acc_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < acc_log.size()) begin
                chk({name, "_data"}, acc_log[i].data, pin_v[i]);
                chk({name, "_row_end"}, acc_log[i].row_end, pin_re[i]);
                chk({name, "_last"}, acc_log[i].last, (i == 5));
            end
        end
        chk({name, "_done_lat"}, done_cyc - last_acc_cyc, 1);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_mat_read"}, mat_read, 0);
        chk({name, "_mat_transpose"}, mat_transpose, 0);
        chk({name, "_mat_m_dim"}, mat_m_dim, 0);
        chk({name, "_mat_n_dim"}, mat_n_dim, 0);
        chk({name, "_mat_m_addr"}, mat_m_addr, 0);
        chk({name, "_mat_n_addr"}, mat_n_addr, 0);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_out_row_end"}, out_row_end, 0);
        chk({name, "_out_last"}, out_last, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
    endtask

    initial begin
        int m;
        int n;
        bit tr;
        #1 reset = 1'b1;
        #2 check_zero("reset");
        @(posedge clk); #3 reset = 1'b0;

        // Row-major 2x3, full throughput.
        rdy_mode = 0;
        fill(2, 3, 0);
        launch(2, 3, 0);
        wait_done(0);
        pin_v = '{1, 2, 3, 4, 5, 6};
        pin_re = '{0, 0, 1, 0, 0, 1};
        pin_seq("rowmajor");
        chk("first_read_lat", first_rd_cyc - start_cyc, 1);
        chk("first_valid_lat", first_val_cyc - start_cyc, 2);
        chk("burst_span", last_acc_cyc - first_val_cyc, 5);

        // Transposed 2x3.
        launch(2, 3, 1);
        wait_done(0);
        pin_v = '{1, 4, 2, 5, 3, 6};
        pin_re = '{0, 1, 0, 1, 0, 1};
        pin_seq("transpose");

        // Back-pressure with ready 1,0,0,1.
        rdy_mode = 1;
        rdy_ph = 0;
        launch(2, 3, 0);
        wait_done(0);
        pin_v = '{1, 2, 3, 4, 5, 6};
        pin_re = '{0, 0, 1, 0, 0, 1};
        pin_seq("stall");

        // Zero-sized matrix.
        rdy_mode = 0;
        launch(0, 4, 0);
        wait_done(0);
        chk("zero_reads", issued, 0);
        chk("zero_valid", valid_cycles, 0);
        chk("zero_done_lat", done_cyc - start_cyc, 1);

        // Start pulsed while busy is ignored.
        launch(2, 3, 0);
        wait_done(1);
        pin_seq("spurious_start");

        // Reset after the third element is accepted.
        launch(2, 3, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (acc_cnt >= 3) break;
        end
        chk("third_accept_seen", acc_cnt >= 3, 1);
        @(posedge clk); #2 reset = 1'b1;
        #1 check_zero("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        repeat (6) @(negedge clk);
        #1 chk("post_reset_valid", valid_cycles, 0);
        launch(2, 3, 0);
        wait_done(0);
        pin_seq("after_reset");

        // Randomized matrices, orders and back-pressure.
        for (int t = 0; t < 25; t++) begin
            m = $urandom_range(0, 6);
            n = $urandom_range(0, 6);
            tr = $urandom_range(0, 1);
            rdy_mode = $urandom_range(0, 2);
            fill(m, n, 1);
            launch(m, n, tr);
            wait_done(0);
            chk("rand_accept_count", acc_cnt, m * n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
